super_acc_drain: RTL and testbench

Sink-side companion to the 16-lane parallel adder array. It accepts 16-lane signed result vectors through a valid/ready handshake and accumulates them lane-wise, with saturation, over a group of beats. When the group ends, it drains the accumulated lanes one per beat over a serial valid/ready output toward the output buffer or memory writer. It sits between the parallel adder stage and the narrow write-back path.

---
 rtl/super_acc_drain.sv | 111 +++++++++++
 tb/tb_super_acc_drain.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/super_acc_drain.sv
// Lane-wise saturating accumulator for 16-lane result vectors.
// At the end of each group it drains the accumulated lanes one per beat over a serial valid/ready port.
module super_acc_drain #(
    parameter int LANES     = 16,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*IN_WIDTH-1:0]     in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic [$clog2(LANES)-1:0]      out_lane,
    output logic                          out_last,
    output logic                          busy
);

    localparam int LW = $clog2(LANES);

    generate
        if (OUT_WIDTH < IN_WIDTH) begin : g_width_check
            $fatal(1, "super_acc_drain: OUT_WIDTH must be >= IN_WIDTH");
        end
    endgenerate

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                      state;
    logic signed [OUT_WIDTH-1:0] acc     [LANES];
    logic signed [OUT_WIDTH-1:0] acc_nxt [LANES];
    logic [LW-1:0]               lane_ptr;
    logic [LW-1:0]               ptr_inc;

    // Sign-extend both operands to OUT_WIDTH+1 bits, then clamp to the OUT_WIDTH range.
    function automatic logic signed [OUT_WIDTH-1:0] acc_add(
        input logic signed [OUT_WIDTH-1:0] a,
        input logic [IN_WIDTH-1:0]         b
    );
        logic signed [OUT_WIDTH:0] s;
        s = {a[OUT_WIDTH-1], a} + {{(OUT_WIDTH+1-IN_WIDTH){b[IN_WIDTH-1]}}, b};
        if (s[OUT_WIDTH] != s[OUT_WIDTH-1])
            acc_add = s[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else
            acc_add = s[OUT_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            acc_nxt[i] = acc_add(acc[i], in_data[i*IN_WIDTH +: IN_WIDTH]);
        end
    end

    assign ptr_inc  = lane_ptr + LW'(1);
    assign out_lane = lane_ptr;

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state     <= ACCUM;
            lane_ptr  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= acc_nxt;
                        if (in_last) begin
                            // Lane 0 is loaded from the freshly updated sum so it is visible next cycle.
                            state     <= DRAIN;
                            lane_ptr  <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            out_data  <= acc_nxt[0];
                            out_last  <= (LANES == 1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= ACCUM;
                            lane_ptr  <= '0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
                        end else begin
                            lane_ptr <= ptr_inc;
                            out_data <= acc[ptr_inc];
                            out_last <= (ptr_inc == LW'(LANES - 1));
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_super_acc_drain.sv
// Directed and randomized bench for super_acc_drain.
// Expected values come from a per-lane integer model with clamping.
module tb_super_acc_drain;

    localparam int LANES = 16;
    localparam int IW    = 16;
    localparam int OW    = 16;
    localparam int MAXV  = 32767;
    localparam int MINV  = -32768;

    typedef int lanes_t[LANES];

    logic                 clk = 1'b0;
    logic                 arst_n_in = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [LANES*IW-1:0]  in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [OW-1:0] out_data;
    logic [3:0]           out_lane;
    logic                 out_last;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    int acc_m[LANES];

    super_acc_drain #(.LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic lanes_t fill(input int v);
        lanes_t r;
        foreach (r[i]) r[i] = v;
        return r;
    endfunction

    function automatic lanes_t rand_lanes();
        lanes_t r;
        foreach (r[i]) r[i] = int'($urandom_range(0, 65535)) - 32768;
        return r;
    endfunction

    task automatic clear_model();
        foreach (acc_m[i]) acc_m[i] = 0;
    endtask

    task automatic pack(input lanes_t v);
        int t;
        for (int i = 0; i < LANES; i++) begin
            t = v[i];
            in_data[i*IW +: IW] = t[IW-1:0];
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge where the beat was taken.
    task automatic send_beat(input lanes_t v, input bit last);
        int cyc = 0;
        pack(v);
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk("in_ready_accum", in_ready, 1);
        @(posedge clk); #1;
        for (int i = 0; i < LANES; i++) acc_m[i] = clamp(acc_m[i] + v[i]);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: fixed stall pattern, 2: random ready.
    task automatic drain(input int mode, input int stop_after, input bit hold_in);
        int idx = 0;
        int cyc = 0;
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        chk("drain_start_valid", out_valid, 1);
        if (hold_in) begin
            pack(rand_lanes());
            in_valid = 1'b1;
            in_last  = 1'b1;
        end
        while (idx < stop_after && cyc < 400) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 6][0] : 1'($urandom_range(0, 1));
            chk("drain_valid", out_valid, 1);
            chk("drain_busy", busy, 1);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_lane", out_lane, idx);
            chk("drain_data", $signed(out_data), acc_m[idx]);
            chk("drain_last", out_last, (idx == LANES - 1));
            @(posedge clk); #1;
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        if (cyc >= 400) chk("drain_timeout", idx, stop_after);
        if (stop_after == LANES) begin
            chk("post_drain_in_ready", in_ready, 1);
            chk("post_drain_valid", out_valid, 0);
            chk("post_drain_busy", busy, 0);
            clear_model();
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_data"}, $signed(out_data), 0);
        chk({tag, "_out_lane"}, out_lane, 0);
        chk({tag, "_out_last"}, out_last, 0);
    endtask

    initial begin
        lanes_t v;
        int nb;
        clear_model();

        // 1: reset held for two cycles
        arst_n_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        arst_n_in = 1'b1;

        // 2: single beat, lane i = i-8
        for (int i = 0; i < LANES; i++) v[i] = i - 8;
        send_beat(v, 1'b1);
        drain(0, LANES, 1'b0);

        // 3: three beats summing to 2500
        send_beat(fill(1000), 1'b0);
        send_beat(fill(2000), 1'b0);
        send_beat(fill(-500), 1'b1);
        chk("sum_2500_lane0", $signed(out_data), 2500);
        drain(0, LANES, 1'b0);

        // 4: saturation both ways, then a clean group
        send_beat(fill(20000), 1'b0);
        send_beat(fill(20000), 1'b1);
        chk("sat_pos_lane0", $signed(out_data), MAXV);
        drain(0, LANES, 1'b0);
        send_beat(fill(-20000), 1'b0);
        send_beat(fill(-20000), 1'b1);
        chk("sat_neg_lane0", $signed(out_data), MINV);
        drain(0, LANES, 1'b0);
        send_beat(fill(5), 1'b1);
        chk("cleared_lane0", $signed(out_data), 5);
        drain(0, LANES, 1'b0);

        // 5: backpressure pattern with in_valid held high during drain
        send_beat(rand_lanes(), 1'b0);
        send_beat(rand_lanes(), 1'b1);
        drain(1, LANES, 1'b1);
        send_beat(fill(3), 1'b1);
        drain(0, LANES, 1'b0);

        // randomized groups with random backpressure
        for (int g = 0; g < 6; g++) begin
            nb = int'($urandom_range(1, 5));
            for (int b = 0; b < nb; b++) send_beat(rand_lanes(), b == nb - 1);
            drain(2, LANES, g[0]);
        end

        // 6: reset after lane-5 handshake
        send_beat(rand_lanes(), 1'b1);
        drain(0, 6, 1'b0);
        arst_n_in = 1'b0;
        @(posedge clk); #1;
        arst_n_in = 1'b1;
        clear_model();
        check_reset_values("mid_reset");
        send_beat(fill(7), 1'b1);
        drain(0, LANES, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
